// File: rtl/txn_arbiter.sv
// Two-requester round-robin arbiter in front of a shared read/write master.
// Grants one transaction at a time, issues it, and waits for completion or timeout.
module txn_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [15:0] cmd0,
  input  logic [15:0] cmd1,
  input  logic        RVALID,
  input  logic        RREADY,
  input  logic        RLAST,
  input  logic        BVALID,
  input  logic        BREADY,
  output logic        en,
  output logic        en_,
  output logic [15:0] tb_R,
  output logic [15:0] tb_W,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, GRANT, ISSUE, WAIT, DONE} state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        wr_q, wr_d;
  logic        err_flag_q, err_flag_d;
  logic [15:0] cmd_q, cmd_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        winner, complete, expired, active;
  logic        gnt0_d, gnt1_d, en_d, en_w_d, done0_d, done1_d, err_d, busy_d;
  logic [15:0] tb_r_d, tb_w_d;

  // Tie goes to the requester that was not served last; a lone request always wins.
  assign winner   = (req0 && req1) ? ~last_q : req1;
  assign complete = wr_q ? (BVALID && BREADY) : (RVALID && RREADY && RLAST);
  assign expired  = (cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    wr_d       = wr_q;
    cmd_d      = cmd_q;
    cnt_d      = cnt_q;
    err_flag_d = err_flag_q;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = GRANT;
          owner_d = winner;
          wr_d    = winner ? wr1 : wr0;
          cmd_d   = winner ? cmd1 : cmd0;
        end
      end
      GRANT: state_d = ISSUE;
      ISSUE: begin
        state_d    = WAIT;
        cnt_d      = '0;
        err_flag_d = 1'b0;
      end
      WAIT: begin
        if (complete) begin
          state_d    = DONE;
          err_flag_d = 1'b0;
        end else if (expired) begin
          state_d    = DONE;
          err_flag_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        last_d  = owner_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so the registered copies line up with state_q.
  always_comb begin
    active  = (state_d == GRANT) || (state_d == ISSUE) || (state_d == WAIT);
    gnt0_d  = active && !owner_d;
    gnt1_d  = active &&  owner_d;
    tb_r_d  = (active && !wr_d) ? cmd_d : 16'h0000;
    tb_w_d  = (active &&  wr_d) ? cmd_d : 16'h0000;
    en_d    = (state_d == ISSUE) && !wr_d;
    en_w_d  = (state_d == ISSUE) &&  wr_d;
    done0_d = (state_d == DONE) && !owner_d;
    done1_d = (state_d == DONE) &&  owner_d;
    err_d   = (state_d == DONE) && err_flag_d;
    busy_d  = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      wr_q       <= 1'b0;
      cmd_q      <= '0;
      cnt_q      <= '0;
      err_flag_q <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      tb_R       <= '0;
      tb_W       <= '0;
      en         <= 1'b0;
      en_        <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      wr_q       <= wr_d;
      cmd_q      <= cmd_d;
      cnt_q      <= cnt_d;
      err_flag_q <= err_flag_d;
      gnt0       <= gnt0_d;
      gnt1       <= gnt1_d;
      tb_R       <= tb_r_d;
      tb_W       <= tb_w_d;
      en         <= en_d;
      en_        <= en_w_d;
      done0      <= done0_d;
      done1      <= done1_d;
      err        <= err_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_txn_arbiter.sv
// Directed bench for txn_arbiter: expected transactions are queued as they are
// requested and checked by a monitor at issue and at completion.
module tb_txn_arbiter;

  localparam int unsigned TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, wr0, wr1;
  logic [15:0] cmd0, cmd1;
  logic        RVALID, RREADY, RLAST, BVALID, BREADY;
  logic        en, en_, gnt0, gnt1, done0, done1, err, busy;
  logic [15:0] tb_R, tb_W;

  typedef struct {
    bit          owner;
    bit          wr;
    logic [15:0] cmd;
    bit          err;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  txn_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1), .cmd0(cmd0), .cmd1(cmd1),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .BVALID(BVALID), .BREADY(BREADY),
    .en(en), .en_(en_), .tb_R(tb_R), .tb_W(tb_W), .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit owner, input bit wr, input logic [15:0] cmd, input bit e);
    exp_t x;
    x.owner = owner; x.wr = wr; x.cmd = cmd; x.err = e;
    sb.push_back(x);
  endtask

  task automatic hs_clear();
    RVALID = 0; RREADY = 0; RLAST = 0; BVALID = 0; BREADY = 0;
  endtask

  task automatic wait_issue();
    int n = 0;
    while (!(en || en_) && n < 12) begin
      tick();
      n++;
    end
    check("issue_timely", 32'(en || en_), 32'd1);
  endtask

  // Waits for the issue pulse, spends lat extra WAIT cycles, then completes.
  task automatic serve(input bit is_wr, input int lat);
    wait_issue();
    tick();
    check("issue_one_cycle", 32'(en || en_), 32'd0);
    repeat (lat) tick();
    if (is_wr) begin
      BVALID = 1; BREADY = 1;
    end else begin
      RVALID = 1; RREADY = 1; RLAST = 1;
    end
    tick();
    hs_clear();
    check("done_pulse", 32'(done0 || done1), 32'd1);
  endtask

  // Monitor: compares issue and completion against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (gnt0 || gnt1) check("gnt_exclusive", 32'(gnt0 && gnt1), 32'd0);
      if (en || en_) begin
        if (sb.size() == 0) begin
          check("issue_expected", 32'd0, 32'd1);
        end else begin
          check("issue_dir", {30'd0, en, en_}, sb[0].wr ? 32'd1 : 32'd2);
          check("issue_gnt", {30'd0, gnt1, gnt0}, sb[0].owner ? 32'd2 : 32'd1);
          check("issue_bus", {tb_R, tb_W}, sb[0].wr ? {16'h0, sb[0].cmd} : {sb[0].cmd, 16'h0});
        end
      end
      if (done0 || done1) begin
        if (sb.size() == 0) begin
          check("done_expected", 32'd0, 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_owner", {30'd0, done1, done0}, e.owner ? 32'd2 : 32'd1);
          check("done_err", 32'(err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1; req0 = 0; req1 = 0; wr0 = 0; wr1 = 0; cmd0 = '0; cmd1 = '0;
    hs_clear();
    tick(); tick();
    check("rst_ctrl", {24'd0, gnt0, gnt1, en, en_, done0, done1, err, busy}, 32'd0);
    check("rst_bus", {tb_R, tb_W}, 32'd0);
    rst = 0;

    // Single read from requester 0, completing 6 cycles after en.
    push(0, 0, 16'h2A31, 0);
    req0 = 1; wr0 = 0; cmd0 = 16'h2A31;
    tick();
    tick();
    check("r030_gnt0", 32'(gnt0), 32'd1);
    check("r030_tbR", 32'(tb_R), 32'h2A31);
    check("r030_tbW", 32'(tb_W), 32'd0);
    serve(0, 5);
    check("r030_done0", 32'(done0), 32'd1);
    check("r030_err", 32'(err), 32'd0);
    req0 = 0;
    tick();
    check("r030_done_once", 32'(done0), 32'd0);
    check("r030_idle", 32'(busy), 32'd0);

    // Simultaneous writes after reset: 0, 1, then the held repeats alternate 0, 1.
    rst = 1; tick(); rst = 0;
    req0 = 1; req1 = 1; wr0 = 1; wr1 = 1; cmd0 = 16'h1101; cmd1 = 16'h2202;
    push(0, 1, 16'h1101, 0);
    push(1, 1, 16'h2202, 0);
    push(0, 1, 16'h1101, 0);
    push(1, 1, 16'h2202, 0);
    serve(1, 1);
    serve(1, 0);
    serve(1, 2);
    serve(1, 1);
    req0 = 0; req1 = 0;
    tick(); tick();

    // Read that never completes times out after TIMEOUT WAIT cycles.
    push(0, 0, 16'h4D10, 1);
    req0 = 1; wr0 = 0; cmd0 = 16'h4D10;
    wait_issue();
    n = 0;
    while (!(done0 || done1) && n < 30) begin
      tick();
      n++;
    end
    check("r032_latency", 32'(n), 32'd9);
    check("r032_err", 32'(err), 32'd1);
    req0 = 0;

    // Write with BREADY held low for 3 cycles; grant must stay up throughout.
    push(1, 1, 16'hB00C, 0);
    req1 = 1; wr1 = 1; cmd1 = 16'hB00C;
    wait_issue();
    tick();
    BVALID = 1; BREADY = 0;
    repeat (3) begin
      tick();
      check("r033_no_done", 32'(done1), 32'd0);
      check("r033_gnt1", 32'(gnt1), 32'd1);
    end
    BREADY = 1;
    tick();
    hs_clear();
    check("r033_done1", 32'(done1), 32'd1);
    check("r033_gnt_clr", 32'(gnt1), 32'd0);
    req1 = 0;
    tick(); tick();

    // Owner drops req in WAIT; RLAST without RREADY must not complete.
    push(0, 0, 16'h3C52, 0);
    req0 = 1; wr0 = 0; cmd0 = 16'h3C52;
    wait_issue();
    tick();
    req0 = 0;
    RVALID = 1; RLAST = 1; RREADY = 0;
    repeat (2) begin
      tick();
      check("r035_no_done", 32'(done0), 32'd0);
      check("r035_gnt0", 32'(gnt0), 32'd1);
    end
    RREADY = 1;
    tick();
    hs_clear();
    check("r035_done0", 32'(done0), 32'd1);
    tick(); tick();

    // Reset during WAIT aborts silently; afterwards a tie goes to requester 0.
    push(0, 0, 16'h5E77, 0);
    req0 = 1; wr0 = 0; cmd0 = 16'h5E77;
    wait_issue();
    tick(); tick();
    rst = 1;
    sb.delete();
    tick();
    check("r034_ctrl", {24'd0, gnt0, gnt1, en, en_, done0, done1, err, busy}, 32'd0);
    check("r034_bus", {tb_R, tb_W}, 32'd0);
    rst = 0;
    req1 = 1; wr1 = 0; cmd1 = 16'h6F88;
    push(0, 0, 16'h5E77, 0);
    push(1, 0, 16'h6F88, 0);
    tick();
    tick();
    check("r034_gnt", {30'd0, gnt1, gnt0}, 32'd1);
    serve(0, 2);
    req0 = 0;
    serve(0, 1);
    req1 = 0;
    tick(); tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("final_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
